// File: rtl/reciprocal_pipe.sv
// ============================================================================
// Module  : reciprocal_pipe
// Brief   : 3-stage pipelined PWL reciprocal z = NUMERATOR/x with valid/ready and tag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module reciprocal_pipe #(
    parameter int WIDTH                    = 32,
    parameter int FRAC_BITS                = 16,
    parameter int NUMERATOR                = 256,
    parameter int END_INTERPOLATION_REGION = 4096,
    parameter int NB_SUBDIVISIONS          = 1024,
    parameter int TAG_W                    = 8
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] x_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] z_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             zero_o,
    output logic             range_o
);

    localparam int c_S     = END_INTERPOLATION_REGION / NB_SUBDIVISIONS;
    localparam int c_L     = $clog2(c_S);
    localparam int c_SEG_W = $clog2(NB_SUBDIVISIONS);
    localparam int c_LO_W  = FRAC_BITS + c_L;
    localparam int c_M_W   = WIDTH - 8;
    localparam int c_P_W   = 2 * WIDTH;

    localparam logic [WIDTH-1:0] c_NUM_Q     = WIDTH'(longint'(NUMERATOR) <<< FRAC_BITS);
    localparam logic [WIDTH-1:0] c_RANGE_LIM = WIDTH'(longint'(END_INTERPOLATION_REGION) <<< FRAC_BITS);
    localparam logic [WIDTH-1:0] c_MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [c_P_W-1:0] c_RND = c_P_W'(longint'(1) <<< (FRAC_BITS - 1));

    if ((END_INTERPOLATION_REGION <= 0) ||
        ((END_INTERPOLATION_REGION & (END_INTERPOLATION_REGION - 1)) != 0)) begin : g_chk_end
        $error("END_INTERPOLATION_REGION must be a power of two");
    end
    if ((NB_SUBDIVISIONS < 2) || ((NB_SUBDIVISIONS & (NB_SUBDIVISIONS - 1)) != 0)) begin : g_chk_nb
        $error("NB_SUBDIVISIONS must be a power of two >= 2");
    end
    if (c_S < 1) begin : g_chk_step
        $error("NB_SUBDIVISIONS must not exceed END_INTERPOLATION_REGION");
    end
    if (($clog2(END_INTERPOLATION_REGION) >= WIDTH - FRAC_BITS - 1) || (FRAC_BITS < 1)) begin : g_chk_fmt
        $error("END_INTERPOLATION_REGION does not fit the integer part of the format");
    end

    // Rounded (NUMERATOR << FRAC_BITS) / v for integer v, i.e. NUMERATOR/v in Q format.
    function automatic longint recip(input longint v);
        longint num_q;
        num_q = longint'(NUMERATOR) <<< FRAC_BITS;
        if (v == 0) return num_q;
        return (num_q + v / 2) / v;
    endfunction

    function automatic logic [WIDTH-1:0] base_at(input int i);
        if (i == 0) return c_NUM_Q;
        return WIDTH'(recip(longint'(i) * c_S));
    endfunction

    function automatic logic [c_M_W-1:0] slope_at(input int i);
        longint d;
        d = recip(longint'(i + 1) * c_S) - longint'(base_at(i));
        return c_M_W'(d >>> c_L);
    endfunction

    logic [WIDTH-1:0] base_rom  [NB_SUBDIVISIONS];
    logic [c_M_W-1:0] slope_rom [NB_SUBDIVISIONS];

    for (genvar gi = 0; gi < NB_SUBDIVISIONS; gi++) begin : g_lut
        assign base_rom[gi]  = base_at(gi);
        assign slope_rom[gi] = slope_at(gi);
    end

    logic w_advance;
    assign w_advance  = !out_valid_o || out_ready_i;
    assign in_ready_o = w_advance;

    // Stage 1 combinational: magnitude split into segment index and in-segment offset.
    logic [WIDTH-1:0]   w_abs;
    logic [c_SEG_W-1:0] w_seg;
    logic [c_LO_W-1:0]  w_frac;
    logic               w_zero;
    logic               w_range;

    assign w_abs   = x_i[WIDTH-1] ? (~x_i + 1'b1) : x_i;
    assign w_seg   = w_abs[c_LO_W +: c_SEG_W];
    assign w_frac  = w_abs[c_LO_W-1:0];
    assign w_zero  = (x_i == '0);
    assign w_range = (w_abs >= c_RANGE_LIM) || (x_i == c_MOST_NEG);

    logic               r1_valid, r1_sign, r1_zero, r1_range;
    logic [c_SEG_W-1:0] r1_seg;
    logic [c_LO_W-1:0]  r1_frac;
    logic [TAG_W-1:0]   r1_tag;

    // Stage 2 combinational: rounded slope * offset.
    logic [c_M_W-1:0]        w_slope;
    logic signed [c_P_W-1:0] w_frac_ext;
    logic signed [c_P_W-1:0] w_slope_ext;
    logic [WIDTH-1:0]        w_p;

    assign w_slope     = slope_rom[r1_seg];
    assign w_frac_ext  = {{(c_P_W-c_LO_W){1'b0}}, r1_frac};
    assign w_slope_ext = {{(c_P_W-c_M_W){w_slope[c_M_W-1]}}, w_slope};
    assign w_p         = WIDTH'((w_frac_ext * w_slope_ext + c_RND) >>> FRAC_BITS);

    logic             r2_valid, r2_sign, r2_zero, r2_range;
    logic [WIDTH-1:0] r2_p, r2_base;
    logic [TAG_W-1:0] r2_tag;

    // Stage 3 combinational: interpolate, restore sign, apply flag overrides.
    logic [WIDTH-1:0] w_mag, w_z;
    assign w_mag = r2_base + r2_p;
    assign w_z   = r2_zero  ? c_NUM_Q :
                   r2_range ? '0 :
                   r2_sign  ? (~w_mag + 1'b1) : w_mag;

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r1_valid    <= 1'b0;
            r1_sign     <= 1'b0;
            r1_zero     <= 1'b0;
            r1_range    <= 1'b0;
            r1_seg      <= '0;
            r1_frac     <= '0;
            r1_tag      <= '0;
            r2_valid    <= 1'b0;
            r2_sign     <= 1'b0;
            r2_zero     <= 1'b0;
            r2_range    <= 1'b0;
            r2_p        <= '0;
            r2_base     <= '0;
            r2_tag      <= '0;
            out_valid_o <= 1'b0;
            z_o         <= '0;
            tag_o       <= '0;
            zero_o      <= 1'b0;
            range_o     <= 1'b0;
        end else if (w_advance) begin
            r1_valid    <= in_valid_i;
            r2_valid    <= r1_valid;
            out_valid_o <= r2_valid;
            // Data registers only load real items so the last result stays visible behind bubbles.
            if (in_valid_i) begin
                r1_sign  <= x_i[WIDTH-1];
                r1_zero  <= w_zero;
                r1_range <= w_range;
                r1_seg   <= w_seg;
                r1_frac  <= w_frac;
                r1_tag   <= tag_i;
            end
            if (r1_valid) begin
                r2_sign  <= r1_sign;
                r2_zero  <= r1_zero;
                r2_range <= r1_range;
                r2_p     <= w_p;
                r2_base  <= base_rom[r1_seg];
                r2_tag   <= r1_tag;
            end
            if (r2_valid) begin
                z_o     <= w_z;
                tag_o   <= r2_tag;
                zero_o  <= r2_zero;
                range_o <= r2_range;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reciprocal_pipe.sv
// ============================================================================
// Module  : tb_reciprocal_pipe
// Brief   : Scoreboard bench for reciprocal_pipe with hand-computed Q16.16 vectors.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reciprocal_pipe;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] x_i;
    logic [7:0]  tag_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] z_o;
    logic [7:0]  tag_o;
    logic        zero_o;
    logic        range_o;

    always #5 clk = ~clk;

    reciprocal_pipe dut (
        .clk         (clk),
        .reset_i     (reset_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .x_i         (x_i),
        .tag_i       (tag_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .z_o         (z_o),
        .tag_o       (tag_o),
        .zero_o      (zero_o),
        .range_o     (range_o)
    );

    typedef struct packed {
        logic [31:0] z;
        logic [7:0]  tag;
        logic        zero;
        logic        range;
    } exp_t;

    exp_t        q[$];
    exp_t        cur_exp;
    exp_t        popped;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_acc = 0;
    logic        rnd_ready_en = 1'b0;
    logic        stall_prev = 1'b0;
    logic [31:0] held_z;
    logic [7:0]  held_tag;
    logic        held_zero, held_range;

    // Stream vectors: x, expected z (PWL result worked out by hand).
    logic [31:0] t4_x [16] = '{32'h00040000, 32'h00080000, 32'h00100000, 32'h00200000,
                               32'h00400000, 32'h01000000, 32'h04000000, 32'h08000000,
                               32'hFFF80000, 32'hFFFF0000, 32'h00020000, 32'h00008000,
                               32'h00004000, 32'h00060000, 32'h000C8000, 32'hFFF40000};
    logic [31:0] t4_z [16] = '{32'h00400000, 32'h00200000, 32'h00100000, 32'h00080000,
                               32'h00040000, 32'h00010000, 32'h00004000, 32'h00002000,
                               32'hFFE00000, 32'hFF300000, 32'h00A00000, 32'h00E80000,
                               32'h00F40000, 32'h00300000, 32'h0014AAAA, 32'hFFEAAAAB};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (reset_i) begin
                stall_prev = 1'b0;
            end else begin
                if (in_valid_i && in_ready_o) begin
                    q.push_back(cur_exp);
                    n_acc++;
                end
                if (stall_prev) begin
                    check("hold_valid", {63'd0, out_valid_o}, 64'd1);
                    check("hold_z", {32'd0, z_o}, {32'd0, held_z});
                    check("hold_tag", {56'd0, tag_o}, {56'd0, held_tag});
                    check("hold_flags", {62'd0, zero_o, range_o}, {62'd0, held_zero, held_range});
                end
                if (out_valid_o && !out_ready_i) begin
                    stall_prev = 1'b1;
                    held_z     = z_o;
                    held_tag   = tag_o;
                    held_zero  = zero_o;
                    held_range = range_o;
                end else begin
                    stall_prev = 1'b0;
                end
                if (out_valid_o && out_ready_i) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_output: got z=%h tag=%h expected no output", z_o, tag_o);
                    end else begin
                        popped = q.pop_front();
                        check("z", {32'd0, z_o}, {32'd0, popped.z});
                        check("tag", {56'd0, tag_o}, {56'd0, popped.tag});
                        check("zero", {63'd0, zero_o}, {63'd0, popped.zero});
                        check("range", {63'd0, range_o}, {63'd0, popped.range});
                    end
                end
            end
        end
    endtask

    task automatic send(input logic [31:0] x, input logic [7:0] tag, input logic [31:0] z,
                        input logic zero, input logic range);
        int budget;
        budget     = 0;
        x_i        = x;
        tag_i      = tag;
        cur_exp    = '{z: z, tag: tag, zero: zero, range: range};
        in_valid_i = 1'b1;
        do begin
            @(negedge clk);
            budget++;
        end while (!in_ready_o && budget < 200);
        if (!in_ready_o) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget      = 0;
        out_ready_i = 1'b1;
        while ((q.size() != 0 || out_valid_o) && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc0;
        reset_i     = 1'b1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        x_i         = '0;
        tag_i       = '0;
        cur_exp     = '0;

        fork
            monitor_loop();
            forever begin
                @(posedge clk);
                #1;
                if (rnd_ready_en) out_ready_i = 1'($urandom_range(0, 1));
            end
            begin
                #1000000;
                $display("FAIL watchdog: got no finish expected finish within time limit");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {63'd0, out_valid_o}, 64'd0);
        check("rst_z", {32'd0, z_o}, 64'd0);
        check("rst_tag", {56'd0, tag_o}, 64'd0);
        check("rst_flags", {62'd0, zero_o, range_o}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready_o}, 64'd1);
        reset_i = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", {63'd0, in_ready_o}, 64'd1);

        // Basic result plus three-cycle latency.
        send(32'h00040000, 8'h11, 32'h00400000, 1'b0, 1'b0);
        check("lat_edge1", {63'd0, out_valid_o}, 64'd0);
        @(posedge clk);
        #1;
        check("lat_edge2", {63'd0, out_valid_o}, 64'd0);
        @(posedge clk);
        #1;
        check("lat_edge3", {63'd0, out_valid_o}, 64'd1);
        drain();

        // Sign, segment-0 interpolation, zero/range flags, boundaries, rounding.
        send(32'hFFFC0000, 8'h21, 32'hFFC00000, 1'b0, 1'b0);
        send(32'h00010000, 8'h22, 32'h00D00000, 1'b0, 1'b0);
        send(32'h00000000, 8'h23, 32'h01000000, 1'b1, 1'b0);
        send(32'h10000000, 8'h24, 32'h00000000, 1'b0, 1'b1);
        send(32'h80000000, 8'h25, 32'h00000000, 1'b0, 1'b1);
        send(32'hF0000000, 8'h26, 32'h00000000, 1'b0, 1'b1);
        send(32'h0FFFFFFF, 8'h27, 32'h00001000, 1'b0, 1'b0);
        send(32'h000C0001, 8'h28, 32'h00155554, 1'b0, 1'b0);
        drain();

        // Back-to-back stream with random backpressure.
        rnd_ready_en = 1'b1;
        for (int i = 0; i < 16; i++) send(t4_x[i], 8'h40 + 8'(i), t4_z[i], 1'b0, 1'b0);
        rnd_ready_en = 1'b0;
        drain();

        // Full-pipe stall: only three items fit.
        out_ready_i = 1'b0;
        acc0 = n_acc;
        send(32'h00100000, 8'h50, 32'h00100000, 1'b0, 1'b0);
        send(32'h00200000, 8'h51, 32'h00080000, 1'b0, 1'b0);
        send(32'h00400000, 8'h52, 32'h00040000, 1'b0, 1'b0);
        x_i        = 32'h00800000;
        tag_i      = 8'h53;
        cur_exp    = '{z: 32'h00020000, tag: 8'h53, zero: 1'b0, range: 1'b0};
        in_valid_i = 1'b1;
        repeat (4) @(negedge clk);
        check("stall_accepted", 64'(n_acc - acc0), 64'd3);
        check("stall_in_ready", {63'd0, in_ready_o}, 64'd0);
        check("stall_out_valid", {63'd0, out_valid_o}, 64'd1);
        @(posedge clk);
        #1;
        out_ready_i = 1'b1;
        send(32'h00800000, 8'h53, 32'h00020000, 1'b0, 1'b0);
        drain();

        // Reset with three items in flight: none may emerge.
        out_ready_i = 1'b0;
        send(32'h00040000, 8'h60, 32'h00400000, 1'b0, 1'b0);
        send(32'h00080000, 8'h61, 32'h00200000, 1'b0, 1'b0);
        send(32'h00100000, 8'h62, 32'h00100000, 1'b0, 1'b0);
        reset_i = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        check("flush_out_valid", {63'd0, out_valid_o}, 64'd0);
        reset_i     = 1'b0;
        out_ready_i = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("flush_quiet", {63'd0, out_valid_o}, 64'd0);
        send(32'h00010000, 8'h70, 32'h00D00000, 1'b0, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
